// File: rtl/dispatch_stall_ctrl_if.sv
// Handshake bundle between the ID/EX stage and the dispatch stall controller.
// The master side is the pipeline or bench; the slave side is the controller.
interface dispatch_stall_ctrl_if #(
  parameter int ROB_DEPTH  = 16,
  parameter int RS_DEPTH   = 8,
  parameter int LSQ_DEPTH  = 8,
  parameter int PREG_AVAIL = 32
);
  localparam int ROB_W  = $clog2(ROB_DEPTH + 1);
  localparam int RS_W   = $clog2(RS_DEPTH + 1);
  localparam int LSQ_W  = $clog2(LSQ_DEPTH + 1);
  localparam int PREG_W = $clog2(PREG_AVAIL + 1);

  logic              inst_valid_i;
  logic [6:0]        opcode_i;
  logic              regWrite_i;
  logic [4:0]        destReg_i;
  logic              memRead_i;
  logic              memWrite_i;
  logic              rob_retire_i;
  logic              rs_issue_i;
  logic              lsq_release_i;
  logic              preg_free_i;
  logic              flush_i;
  logic              dispatch_o;
  logic              stall_o;
  logic              flushing_o;
  logic [ROB_W-1:0]  rob_cnt_o;
  logic [RS_W-1:0]   rs_cnt_o;
  logic [LSQ_W-1:0]  lsq_cnt_o;
  logic [PREG_W-1:0] preg_cnt_o;
  logic [15:0]       stall_cnt_o;
  logic              err_o;

  modport master (
    output inst_valid_i, opcode_i, regWrite_i, destReg_i, memRead_i, memWrite_i,
           rob_retire_i, rs_issue_i, lsq_release_i, preg_free_i, flush_i,
    input  dispatch_o, stall_o, flushing_o, rob_cnt_o, rs_cnt_o, lsq_cnt_o,
           preg_cnt_o, stall_cnt_o, err_o
  );

  modport slave (
    input  inst_valid_i, opcode_i, regWrite_i, destReg_i, memRead_i, memWrite_i,
           rob_retire_i, rs_issue_i, lsq_release_i, preg_free_i, flush_i,
    output dispatch_o, stall_o, flushing_o, rob_cnt_o, rs_cnt_o, lsq_cnt_o,
           preg_cnt_o, stall_cnt_o, err_o
  );
endinterface

// File: rtl/dispatch_stall_ctrl.sv
// ID/EX dispatch controller: credit tracking for ROB/RS/LSQ/rename regs, stall generation,
// and a fixed-length flush window after a mispredict or exception.
//
// state   | meaning
// S_RUN   | normal dispatch; stall only on missing credit
// S_FLUSH | recovery window; dispatch blocked, stall forced, down-counter running
module dispatch_stall_ctrl #(
  parameter int ROB_DEPTH    = 16,
  parameter int RS_DEPTH     = 8,
  parameter int LSQ_DEPTH    = 8,
  parameter int PREG_AVAIL   = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  dispatch_stall_ctrl_if.slave bus
);
  localparam int ROB_W  = $clog2(ROB_DEPTH + 1);
  localparam int RS_W   = $clog2(RS_DEPTH + 1);
  localparam int LSQ_W  = $clog2(LSQ_DEPTH + 1);
  localparam int PREG_W = $clog2(PREG_AVAIL + 1);
  localparam int FW     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [ROB_W-1:0]  rob_q, rob_d;
  logic [RS_W-1:0]   rs_q, rs_d;
  logic [LSQ_W-1:0]  lsq_q, lsq_d;
  logic [PREG_W-1:0] preg_q, preg_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic              err_q, err_d;
  logic              flushing_q, flushing_d;

  logic req, need_lsq, need_preg, ok, dispatch, stall;

  // Credit check uses registered counts only; releases this cycle never grant credit.
  always_comb begin
    req       = bus.inst_valid_i && (bus.opcode_i != 7'h00);
    need_lsq  = bus.memRead_i || bus.memWrite_i;
    need_preg = bus.regWrite_i && (bus.destReg_i != 5'd0);
    ok        = (rob_q < ROB_W'(ROB_DEPTH)) && (rs_q < RS_W'(RS_DEPTH)) &&
                (!need_lsq  || (lsq_q  < LSQ_W'(LSQ_DEPTH))) &&
                (!need_preg || (preg_q < PREG_W'(PREG_AVAIL)));
    dispatch  = rstn && (state_q == S_RUN) && !bus.flush_i && req && ok;
    stall     = rstn && ((state_q == S_FLUSH) || (req && !ok));
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    rob_d       = rob_q;
    rs_d        = rs_q;
    lsq_d       = lsq_q;
    preg_d      = preg_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;

    if ((state_q == S_RUN) && stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;

    if (bus.flush_i) begin
      state_d = S_FLUSH;
      fcnt_d  = FW'(FLUSH_CYCLES - 1);
      rob_d   = '0;
      rs_d    = '0;
      lsq_d   = '0;
      preg_d  = '0;
    end else begin
      if (state_q == S_FLUSH) begin
        if (fcnt_q == '0) state_d = S_RUN;
        else              fcnt_d  = fcnt_q - FW'(1);
      end
      // A release against an empty counter is an underflow: ignore it and flag it.
      if ((bus.rob_retire_i  && rob_q  == '0) || (bus.rs_issue_i  && rs_q   == '0) ||
          (bus.lsq_release_i && lsq_q  == '0) || (bus.preg_free_i && preg_q == '0))
        err_d = 1'b1;
      rob_d  = rob_q  + ROB_W'(dispatch)
                      - ROB_W'(bus.rob_retire_i && (rob_q != '0));
      rs_d   = rs_q   + RS_W'(dispatch)
                      - RS_W'(bus.rs_issue_i && (rs_q != '0));
      lsq_d  = lsq_q  + LSQ_W'(dispatch && need_lsq)
                      - LSQ_W'(bus.lsq_release_i && (lsq_q != '0));
      preg_d = preg_q + PREG_W'(dispatch && need_preg)
                      - PREG_W'(bus.preg_free_i && (preg_q != '0));
    end
    flushing_d = (state_d == S_FLUSH);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_RUN;
      fcnt_q      <= '0;
      rob_q       <= '0;
      rs_q        <= '0;
      lsq_q       <= '0;
      preg_q      <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
      flushing_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      rob_q       <= rob_d;
      rs_q        <= rs_d;
      lsq_q       <= lsq_d;
      preg_q      <= preg_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
      flushing_q  <= flushing_d;
    end
  end

  assign bus.dispatch_o  = dispatch;
  assign bus.stall_o     = stall;
  assign bus.flushing_o  = flushing_q;
  assign bus.rob_cnt_o   = rob_q;
  assign bus.rs_cnt_o    = rs_q;
  assign bus.lsq_cnt_o   = lsq_q;
  assign bus.preg_cnt_o  = preg_q;
  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_dispatch_stall_ctrl.sv
// Directed bench for dispatch_stall_ctrl with a behavioural credit model feeding a
// scoreboard of per-cycle combinational and registered expectations.
module tb_dispatch_stall_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dispatch_stall_ctrl_if bus ();
  dispatch_stall_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    logic disp;
    logic stall;
  } comb_t;

  typedef struct {
    int  rob, rs, lsq, preg, scnt;
    bit  flushing, err;
  } reg_t;

  comb_t qc[$];
  reg_t  qr[$];

  int total = 0;
  int bad   = 0;

  // model state
  int m_rob, m_rs, m_lsq, m_preg, m_scnt, m_fc;
  bit m_flush, m_err;
  logic last_disp, last_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.inst_valid_i = 0; bus.opcode_i = 7'h00; bus.regWrite_i = 0; bus.destReg_i = 5'd0;
    bus.memRead_i = 0; bus.memWrite_i = 0; bus.rob_retire_i = 0; bus.rs_issue_i = 0;
    bus.lsq_release_i = 0; bus.preg_free_i = 0; bus.flush_i = 0;
  endtask

  task automatic op(input logic [6:0] opc, input bit rw, input logic [4:0] rd, input bit mr, input bit mw);
    bus.inst_valid_i = 1; bus.opcode_i = opc; bus.regWrite_i = rw; bus.destReg_i = rd;
    bus.memRead_i = mr; bus.memWrite_i = mw;
  endtask

  function automatic int upd(input int cnt, input bit inc, input bit rel, inout bit err);
    if (rel && cnt == 0) begin
      err = 1;
      return cnt + int'(inc);
    end
    return cnt + int'(inc) - int'(rel);
  endfunction

  // One clock: push expectations for the driven inputs, compare at negedge and after posedge.
  task automatic tick(input bit chk);
    comb_t c; reg_t r; bit req, nl, np, ok, e;
    req = bus.inst_valid_i && (bus.opcode_i != 0);
    nl  = bus.memRead_i || bus.memWrite_i;
    np  = bus.regWrite_i && (bus.destReg_i != 0);
    ok  = (m_rob < 16) && (m_rs < 8) && (!nl || m_lsq < 8) && (!np || m_preg < 32);
    c.disp  = !m_flush && !bus.flush_i && req && ok;
    c.stall = m_flush || (req && !ok);
    qc.push_back(c);
    e = m_err;
    r.scnt = (!m_flush && c.stall && m_scnt < 65535) ? m_scnt + 1 : m_scnt;
    if (bus.flush_i) begin
      r.rob = 0; r.rs = 0; r.lsq = 0; r.preg = 0; r.flushing = 1;
      m_fc = 1;
    end else begin
      r.rob  = upd(m_rob,  c.disp,       bus.rob_retire_i,  e);
      r.rs   = upd(m_rs,   c.disp,       bus.rs_issue_i,    e);
      r.lsq  = upd(m_lsq,  c.disp && nl, bus.lsq_release_i, e);
      r.preg = upd(m_preg, c.disp && np, bus.preg_free_i,   e);
      if (m_flush && m_fc == 0) r.flushing = 0;
      else begin
        r.flushing = m_flush;
        if (m_flush) m_fc--;
      end
    end
    r.err = e;
    qr.push_back(r);

    @(negedge clk);
    c = qc.pop_front();
    last_disp  = bus.dispatch_o;
    last_stall = bus.stall_o;
    if (chk) begin
      check("dispatch", 32'(bus.dispatch_o), 32'(c.disp));
      check("stall",    32'(bus.stall_o),    32'(c.stall));
    end
    @(posedge clk); #1;
    r = qr.pop_front();
    m_rob = r.rob; m_rs = r.rs; m_lsq = r.lsq; m_preg = r.preg;
    m_scnt = r.scnt; m_flush = r.flushing; m_err = r.err;
    if (chk) begin
      check("rob_cnt",   32'(bus.rob_cnt_o),   32'(r.rob));
      check("rs_cnt",    32'(bus.rs_cnt_o),    32'(r.rs));
      check("lsq_cnt",   32'(bus.lsq_cnt_o),   32'(r.lsq));
      check("preg_cnt",  32'(bus.preg_cnt_o),  32'(r.preg));
      check("stall_cnt", 32'(bus.stall_cnt_o), 32'(r.scnt));
      check("flushing",  32'(bus.flushing_o),  32'(r.flushing));
      check("err",       32'(bus.err_o),       32'(r.err));
    end
  endtask

  // Reset asserted asynchronously; a valid ALU op is left on the inputs to prove dispatch is held low.
  task automatic do_reset();
    clr();
    op(7'h33, 1, 5'd5, 0, 0);
    #2 rstn = 0;
    #1;
    m_rob = 0; m_rs = 0; m_lsq = 0; m_preg = 0; m_scnt = 0; m_fc = 0; m_flush = 0; m_err = 0;
    check("rst_dispatch",  32'(bus.dispatch_o),  32'd0);
    check("rst_flushing",  32'(bus.flushing_o),  32'd0);
    check("rst_rob",       32'(bus.rob_cnt_o),   32'd0);
    check("rst_rs",        32'(bus.rs_cnt_o),    32'd0);
    check("rst_lsq",       32'(bus.lsq_cnt_o),   32'd0);
    check("rst_preg",      32'(bus.preg_cnt_o),  32'd0);
    check("rst_stall_cnt", 32'(bus.stall_cnt_o), 32'd0);
    check("rst_err",       32'(bus.err_o),       32'd0);
    @(negedge clk);
    rstn = 1;
    clr();
    @(posedge clk); #1;
  endtask

  initial begin
    clr();
    rstn = 1;
    @(posedge clk); #1;

    // 1) 16 back-to-back ALU ops fill the ROB; RS drained from the 2nd op on
    do_reset();
    for (int i = 0; i < 16; i++) begin
      clr(); op(7'h33, 1, 5'd5, 0, 0);
      bus.rs_issue_i = (i != 0);
      tick(1);
      check("s1_dispatch", 32'(last_disp), 32'd1);
    end
    check("s1_rob_full", 32'(bus.rob_cnt_o), 32'd16);
    clr(); op(7'h33, 1, 5'd5, 0, 0);
    tick(1);
    check("s1_stall17", 32'(last_stall), 32'd1);

    // 2) retire on the stalled cycle gives no same-cycle credit
    clr(); op(7'h33, 1, 5'd5, 0, 0); bus.rob_retire_i = 1;
    tick(1);
    check("s2_still_stall", 32'(last_stall), 32'd1);
    clr(); op(7'h33, 1, 5'd5, 0, 0);
    tick(1);
    check("s2_dispatch", 32'(last_disp), 32'd1);
    check("s2_rob16", 32'(bus.rob_cnt_o), 32'd16);

    // 6a) hold the resource stall until the stall counter saturates
    clr(); op(7'h33, 1, 5'd5, 0, 0);
    for (int i = 0; i < 70000; i++) tick(i >= 69995);
    check("s6_saturate", 32'(bus.stall_cnt_o), 32'h0000FFFF);

    // 3) 8 loads fill the LSQ; 9th load stalls; rd=0 ALU op needs no rename reg
    do_reset();
    for (int i = 0; i < 8; i++) begin
      clr(); op(7'h03, 1, 5'd7, 1, 0);
      bus.rs_issue_i = (i != 0);
      tick(1);
    end
    check("s3_lsq8", 32'(bus.lsq_cnt_o), 32'd8);
    clr(); op(7'h03, 1, 5'd7, 1, 0);
    tick(1);
    check("s3_load9_stall", 32'(last_stall), 32'd1);
    clr(); op(7'h33, 1, 5'd0, 0, 0);
    tick(1);
    check("s3_alu_rd0_disp", 32'(last_disp), 32'd1);
    check("s3_preg_same", 32'(bus.preg_cnt_o), 32'd8);

    // 4) flush with nonzero counters; store also exercises memWrite path after recovery
    clr(); op(7'h33, 1, 5'd3, 0, 0); bus.flush_i = 1; bus.lsq_release_i = 1;
    tick(1);
    check("s4_flush_nodisp", 32'(last_disp), 32'd0);
    check("s4_rob0", 32'(bus.rob_cnt_o), 32'd0);
    check("s4_lsq0", 32'(bus.lsq_cnt_o), 32'd0);
    clr(); op(7'h23, 0, 5'd0, 0, 1);
    tick(1);
    check("s4_flushing_c1", 32'(last_stall), 32'd1);
    tick(1);
    check("s4_flushing_c2", 32'(last_disp), 32'd0);
    check("s4_run_again", 32'(bus.flushing_o), 32'd0);
    tick(1);
    check("s4_resume_c3", 32'(last_disp), 32'd1);
    check("s4_store_lsq", 32'(bus.lsq_cnt_o), 32'd1);

    // flush during FLUSH restarts the window
    clr(); bus.flush_i = 1;
    tick(1);
    clr(); tick(1);
    clr(); bus.flush_i = 1;
    tick(1);
    clr(); tick(1);
    check("s4_restart", 32'(bus.flushing_o), 32'd1);
    tick(1);

    // 5) underflow on RS sets sticky err; bubble opcode never dispatches or stalls
    do_reset();
    clr(); bus.rs_issue_i = 1;
    tick(1);
    check("s5_rs0", 32'(bus.rs_cnt_o), 32'd0);
    check("s5_err", 32'(bus.err_o), 32'd1);
    clr(); op(7'h00, 1, 5'd9, 0, 0);
    tick(1);
    check("s5_bubble_disp", 32'(last_disp), 32'd0);
    check("s5_bubble_stall", 32'(last_stall), 32'd0);
    check("s5_err_hold", 32'(bus.err_o), 32'd1);
    clr(); op(7'h13, 1, 5'd4, 0, 0); bus.preg_free_i = 1;
    tick(1);

    // 6b) asynchronous reset in the middle of a flush window
    clr(); op(7'h33, 1, 5'd5, 0, 0);
    tick(1);
    clr(); bus.flush_i = 1;
    tick(1);
    check("s6_in_flush", 32'(bus.flushing_o), 32'd1);
    do_reset();
    clr(); op(7'h33, 1, 5'd5, 0, 0);
    tick(1);
    check("s6_post_reset_disp", 32'(last_disp), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
